io_fifo_port: RTL and testbench
===============================

# io_fifo_port

I/O-mapped byte FIFO peripheral on the 8088 demultiplexed bus. Consumes the latched 20-bit address, ALE, IO/M, RD and WR strobes, and the shared bidirectional data bus produced by the processor-side bus interface. Decodes two consecutive I/O ports, buffers bytes written by the CPU, returns them on reads, exposes a status register, and raises a level interrupt request at a fill threshold.

## Interface
- BASE_PORT, 16'h0080: I/O port of the data register; status register is BASE_PORT+1; must be even.
- DEPTH, 16: FIFO entries; power of two, 4..256.
- THRESH, 8: IRQ asserts when count >= THRESH; 1..DEPTH.
- CLK  input  1  bus clock; the only clock.
- RESET  input  1  asynchronous, active-high reset.
- ALE  input  1  address latch enable, active high.
- IOM  input  1  1 = I/O cycle, 0 = memory cycle.
- RD  input  1  read strobe, active low.
- WR  input  1  write strobe, active low.
- Address  input  20  demultiplexed bus address; only [15:0] is decoded.
- Data  inout  8  shared data bus; driven only during a selected read.
- IRQ  output  1  interrupt request, level, active high.

## Operation
- Bus FSM states: IDLE, ADDR, RD_ACT, WR_ACT.
- IDLE: on ALE=1, register IOM and Address[15:0]; sel = IOM & (Address[15:1] == BASE_PORT[15:1]); reg = Address[0]; go to ADDR.
- ADDR: RD=0 & sel -> RD_ACT; WR=0 & sel -> WR_ACT; RD=0 or WR=0 with sel=0 -> IDLE (cycle ignored); ALE=1 again -> re-latch and stay in ADDR.
- RD_ACT: Data driven with the selected register while RD=0. On the RD 0->1 edge (registered previous RD compared with current RD): if reg=0, pop; if reg=1, clear sticky bits. Then IDLE.
- WR_ACT: Data sampled every cycle while WR=0; last sample before the WR 0->1 edge commits. reg=0: push. reg=1: bit7=1 flushes the FIFO (count=0, pointers=0, sticky bits cleared); other bits ignored. Then IDLE.
- Data register read: head byte; if empty, returns 8'h00, no pop, sets underflow.
- Data register write when full: byte dropped, sets overflow, FIFO unchanged.
- Status byte: [0] empty, [1] full, [2] overflow (sticky), [3] underflow (sticky), [4] IRQ, [7:5] 0.
- Count width $clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- IRQ = (count >= THRESH), registered.
- RD=0 and WR=0 simultaneously in ADDR: RD wins; the write is ignored.

## Timing
- Reset values: FSM IDLE, Data released (Z), IRQ=0, count=0, pointers=0, sticky bits=0.
- Address/sel captured on the first rising CLK edge with ALE=1.
- Read data is combinational from the head entry or status register, gated by state==RD_ACT & RD=0. It appears in the same cycle RD is sampled low, and Data returns to Z the cycle RD goes high.
- Pop or sticky clear takes effect one CLK after the RD rising edge is detected. Push or flush takes effect one CLK after the WR rising edge is detected.
- IRQ updates one CLK after the count changes.
- RESET asserted mid-cycle: Data is released immediately (asynchronous), the FSM returns to IDLE, the FIFO is emptied, and the pending push or pop is discarded.
- No wait states; READY is never driven.

## Structure
- The shared package intel8088_pkg holds:
  - bus_state_t enum (IDLE, ADDR, RD_ACT, WR_ACT);
  - register offsets REG_DATA=1'b0 and REG_STATUS=1'b1;
  - status bit indices ST_EMPTY, ST_FULL, ST_OVF, ST_UNF, ST_IRQ;
  - the flush bit index CTL_FLUSH=7.
- The sub-module sync_fifo (parameters WIDTH, DEPTH) provides push, pop, flush, head data, count, full, and empty, with asynchronous active-high reset. The top level owns the bus FSM, decode, sticky bits, and tri-state.
- Connects to the Peripheral side of the 8088 pin interface; IOM is taken from the processor-side pins.

## Test plan
- Reset, then three I/O writes to 0x0080 of 0x11, 0x22, 0x33, then three reads -> reads return 0x11, 0x22, 0x33. A status read after the writes returns 0x00; a status read after the reads returns 0x01.
- 17 writes with DEPTH=16 -> the 17th byte is dropped and status returns 0x16 (full, overflow, IRQ). A second status read returns 0x12 (sticky bit cleared).
- Read 0x0080 when empty -> Data=0x00, status=0x09. A second status read returns 0x01.
- THRESH=8: 7 writes -> IRQ=0; the 8th write -> IRQ=1 one CLK after the commit. One read -> IRQ=0.
- Memory write (IOM=0) to 0x00080, and an I/O write to 0x0082 -> FIFO unchanged and Data never driven. Write 0x80 to 0x0081 with 5 entries queued -> status returns 0x01.
- RESET asserted while RD=0 in RD_ACT with 2 entries queued -> Data becomes Z immediately, IRQ=0, and status after release reads 0x01.

Source files
------------

// File: rtl/intel8088_pkg.sv
// Shared definitions for 8088-bus peripherals: bus FSM states, register
// offsets and bit positions of the FIFO port status/control bytes.
package intel8088_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, RD_ACT, WR_ACT} bus_state_t;

   localparam logic REG_DATA   = 1'b0;
   localparam logic REG_STATUS = 1'b1;

   localparam int ST_EMPTY  = 0;
   localparam int ST_FULL   = 1;
   localparam int ST_OVF    = 2;
   localparam int ST_UNF    = 3;
   localparam int ST_IRQ    = 4;
   localparam int CTL_FLUSH = 7;

endpackage

// File: rtl/io_fifo_port_sync_fifo.sv
// Single-clock circular FIFO with push/pop/flush; push when full and pop when
// empty are ignored so the caller only has to track the sticky error bits.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;
   assign head    = mem[rd_ptr];

   // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/io_fifo_port.sv
// I/O-mapped byte FIFO on the demultiplexed 8088 bus: data register at
// BASE_PORT, status/control at BASE_PORT+1, level IRQ at a fill threshold.
module io_fifo_port
   import intel8088_pkg::*;
#(
   parameter logic [15:0] BASE_PORT = 16'h0080,
   parameter int          DEPTH     = 16,
   parameter int          THRESH    = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ALE,
   input  logic        IOM,
   input  logic        RD,
   input  logic        WR,
   input  logic [19:0] Address,
   inout  wire  [7:0]  Data,
   output logic        IRQ
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] THR = CW'(THRESH);

   bus_state_t     state, nxt;
   logic           sel_q, reg_q, rd_q, wr_q;
   logic           latch, push, pop, flush, set_ovf, set_unf, clr_st;
   logic           ovf, unf, drive;
   logic [7:0]     wdata, head, status, rdata;
   logic [CW-1:0]  count;
   logic           full, empty;
   logic           addr_unused;

   assign addr_unused = ^Address[19:16];

   sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
      .clk   (CLK),
      .rst   (RESET),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (wdata),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      nxt     = state;
      latch   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      flush   = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      clr_st  = 1'b0;
      case (state)
         IDLE: if (ALE) begin
            latch = 1'b1;
            nxt   = ADDR;
         end
         ADDR: begin
            if (ALE)      latch = 1'b1;
            else if (!RD) nxt = sel_q ? RD_ACT : IDLE;   // RD wins over WR
            else if (!WR) nxt = sel_q ? WR_ACT : IDLE;
         end
         RD_ACT: if (!rd_q && RD) begin
            nxt = IDLE;
            if (reg_q == REG_DATA) begin
               if (empty) set_unf = 1'b1;
               else       pop     = 1'b1;
            end else begin
               clr_st = 1'b1;
            end
         end
         WR_ACT: if (!wr_q && WR) begin
            nxt = IDLE;
            if (reg_q == REG_DATA) begin
               if (full) set_ovf = 1'b1;
               else      push    = 1'b1;
            end else if (wdata[CTL_FLUSH]) begin
               flush = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         sel_q <= 1'b0;
         reg_q <= REG_DATA;
         rd_q  <= 1'b1;
         wr_q  <= 1'b1;
         wdata <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
         IRQ   <= 1'b0;
      end else begin
         state <= nxt;
         rd_q  <= RD;
         wr_q  <= WR;
         if (latch) begin
            sel_q <= IOM & (Address[15:1] == BASE_PORT[15:1]);
            reg_q <= Address[0];
         end
         // Keep the most recent byte seen while WR is low; it commits on WR rise.
         if (!WR && (state == ADDR || state == WR_ACT)) wdata <= Data;
         if (flush || clr_st) begin
            ovf <= 1'b0;
            unf <= 1'b0;
         end else begin
            if (set_ovf) ovf <= 1'b1;
            if (set_unf) unf <= 1'b1;
         end
         IRQ <= (count >= THR);
      end
   end

   always_comb begin
      status           = '0;
      status[ST_EMPTY] = empty;
      status[ST_FULL]  = full;
      status[ST_OVF]   = ovf;
      status[ST_UNF]   = unf;
      status[ST_IRQ]   = IRQ;
   end

   assign rdata = (reg_q == REG_STATUS) ? status : (empty ? 8'h00 : head);
   assign drive = (state == RD_ACT) & ~RD;
   assign Data  = drive ? rdata : 8'bz;

endmodule

// File: tb/tb_io_fifo_port.sv
// Directed bench for io_fifo_port: bus-cycle tasks, a byte queue as the
// scoreboard for data reads, fixed expectations for status bytes.
module tb_io_fifo_port;
   logic        CLK = 1'b0;
   logic        RESET, ALE, IOM, RD, WR;
   logic [19:0] Address;
   logic        drv;
   logic [7:0]  dout;
   tri1  [7:0]  Data;
   logic        IRQ;

   logic [7:0]  q [$];
   int          checks = 0;
   int          errors = 0;

   assign Data = drv ? dout : 8'bz;

   io_fifo_port #(.BASE_PORT(16'h0080), .DEPTH(16), .THRESH(8)) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .ALE     (ALE),
      .IOM     (IOM),
      .RD      (RD),
      .WR      (WR),
      .Address (Address),
      .Data    (Data),
      .IRQ     (IRQ)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic io_write(input logic [19:0] a, input logic iom, input logic [7:0] d);
      @(negedge CLK); ALE = 1'b1; Address = a; IOM = iom;
      @(negedge CLK); ALE = 1'b0;
      @(negedge CLK); WR = 1'b0; drv = 1'b1; dout = d;
      @(negedge CLK);
      @(negedge CLK); WR = 1'b1; drv = 1'b0;
      @(negedge CLK);
      if (iom && a[15:1] == 15'h0040) begin
         if (!a[0]) begin
            if (q.size() < 16) q.push_back(d);
         end else if (d[7]) begin
            q.delete();
         end
      end
   endtask

   task automatic io_read(input logic [19:0] a, output logic [7:0] v);
      @(negedge CLK); ALE = 1'b1; Address = a; IOM = 1'b1;
      @(negedge CLK); ALE = 1'b0;
      @(negedge CLK); RD = 1'b0;
      @(negedge CLK); v = Data;
      @(negedge CLK); RD = 1'b1;
      @(negedge CLK);
      chk("release_after_read", Data, 8'hFF);
   endtask

   task automatic read_data(input string tag);
      logic [7:0] v, exp;
      io_read(20'h00080, v);
      exp = (q.size() > 0) ? q.pop_front() : 8'h00;
      chk(tag, v, exp);
   endtask

   task automatic read_status(input string tag, input logic [7:0] exp);
      logic [7:0] v;
      io_read(20'h00081, v);
      chk(tag, v, exp);
   endtask

   initial begin
      logic [7:0] v;
      RESET = 1'b1; ALE = 1'b0; IOM = 1'b0; RD = 1'b1; WR = 1'b1;
      Address = '0; drv = 1'b0; dout = '0;
      repeat (3) @(negedge CLK);
      chk("reset_irq", {7'b0, IRQ}, 8'h00);
      chk("reset_data_z", Data, 8'hFF);
      RESET = 1'b0;
      @(negedge CLK);

      // basic FIFO order
      io_write(20'h00080, 1'b1, 8'h11);
      io_write(20'h00080, 1'b1, 8'h22);
      io_write(20'h00080, 1'b1, 8'h33);
      read_status("status_3q", 8'h00);
      repeat (3) read_data("data_basic");
      read_status("status_empty", 8'h01);

      // overflow on 17th write, then drain across the pointer wrap
      for (int i = 0; i < 17; i++) io_write(20'h00080, 1'b1, 8'h40 + 8'(i));
      read_status("status_full_ovf", 8'h16);
      read_status("status_ovf_cleared", 8'h12);
      repeat (16) read_data("data_drain");

      // underflow
      read_data("data_empty_read");
      read_status("status_unf", 8'h09);
      read_status("status_unf_cleared", 8'h01);

      // IRQ threshold
      for (int i = 0; i < 7; i++) io_write(20'h00080, 1'b1, 8'hA0 + 8'(i));
      chk("irq_7", {7'b0, IRQ}, 8'h00);
      io_write(20'h00080, 1'b1, 8'hA7);
      chk("irq_8_before", {7'b0, IRQ}, 8'h00);
      @(negedge CLK);
      chk("irq_8_after", {7'b0, IRQ}, 8'h01);
      read_data("data_irq_pop");
      @(negedge CLK);
      chk("irq_after_pop", {7'b0, IRQ}, 8'h00);
      repeat (7) read_data("data_irq_drain");

      // decode: memory cycle and neighbouring port are ignored
      io_write(20'h00080, 1'b0, 8'h5A);
      io_write(20'h00082, 1'b1, 8'h5B);
      io_read(20'h00082, v);
      chk("unselected_read_z", v, 8'hFF);
      read_status("status_decode", 8'h01);

      // flush via control write
      for (int i = 0; i < 5; i++) io_write(20'h00080, 1'b1, 8'hC0 + 8'(i));
      read_status("status_5q", 8'h00);
      io_write(20'h00081, 1'b1, 8'h80);
      read_status("status_flushed", 8'h01);

      // reset in the middle of a data read
      io_write(20'h00080, 1'b1, 8'hD1);
      io_write(20'h00080, 1'b1, 8'hD2);
      @(negedge CLK); ALE = 1'b1; Address = 20'h00080; IOM = 1'b1;
      @(negedge CLK); ALE = 1'b0;
      @(negedge CLK); RD = 1'b0;
      @(negedge CLK);
      chk("rst_read_head", Data, q[0]);
      #2 RESET = 1'b1;
      #1;
      chk("rst_data_z", Data, 8'hFF);
      chk("rst_irq", {7'b0, IRQ}, 8'h00);
      q.delete();
      @(negedge CLK); RD = 1'b1;
      @(negedge CLK); RESET = 1'b0;
      @(negedge CLK);
      read_status("status_after_reset", 8'h01);
      read_data("data_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
